int_ctrl: RTL

INT_CTRL -- requirements
Module: int_ctrl

---
 rtl/int_ctrl_pkg.sv | 23 ++
 rtl/int_prio_enc.sv | 25 ++
 rtl/int_ctrl.sv | 134 +++++++++++++
 3 files changed

// File: rtl/int_ctrl_pkg.sv
// Shared types and constants for the interrupt controller.
package int_ctrl_pkg;

    // Default number of interrupt sources (bit 0 = timer0, bit 1 = timer1).
    localparam int NUM_SRC = 6;

    // Width of a source index (int_id and the in-service id in STATUS).
    localparam int ID_W = 3;

    // Register word addresses (byte address bits [3:2]).
    localparam logic [1:0] ADDR_MASK   = 2'd0;
    localparam logic [1:0] ADDR_MODE   = 2'd1;
    localparam logic [1:0] ADDR_PEND   = 2'd2;
    localparam logic [1:0] ADDR_STATUS = 2'd3;

    // Request/service handshake with the CPU.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_e;

endpackage

// File: rtl/int_prio_enc.sv
// Lowest-index-first priority encoder over the eligible interrupt sources.
module int_prio_enc
    import int_ctrl_pkg::*;
#(
    parameter int N = int_ctrl_pkg::NUM_SRC
) (
    input  logic [N-1:0]    req_i,
    output logic            valid_o,
    output logic [ID_W-1:0] id_o
);

    // Scan from the top down so the lowest set index is the last one written.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        valid_o = 1'b0;
        id_o    = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                valid_o = 1'b1;
                id_o    = ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/int_ctrl.sv
// Interrupt controller: MASK/MODE/PEND/STATUS registers, edge/level capture,
// fixed lowest-index priority and a non-nesting request/service handshake.
module int_ctrl #(
    parameter int NUM_SRC = int_ctrl_pkg::NUM_SRC
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] irq_in,
    input  logic [1:0]         addr,
    input  logic               we,
    input  logic [31:0]        wdata,
    output logic [31:0]        rdata,
    output logic               int_req,
    output logic [2:0]         int_id,
    input  logic               int_ack,
    input  logic               eret
);

    import int_ctrl_pkg::*;

    logic [NUM_SRC-1:0] mask_q, mode_q, irq_q;
    logic [NUM_SRC-1:0] pend_e_q, pend_e_d;
    logic [NUM_SRC-1:0] pend, eligible, set_evt, clr;
    state_e             state_q, state_d;
    logic               busy_q, busy_d;
    logic [ID_W-1:0]    isr_id_q, isr_id_d;
    logic               int_req_d;
    logic [ID_W-1:0]    int_id_d;
    logic               enc_valid;
    logic [ID_W-1:0]    enc_id;
    logic               ack_take, eret_take;
    logic               unused_wdata;

    // Only the low NUM_SRC write-data bits carry register content.
    assign unused_wdata = ^wdata[31:NUM_SRC];

    assign ack_take  = (state_q == ST_REQ) && int_ack;
    assign eret_take = (state_q == ST_SERVICE) && eret;

    // Edge sources latch rising edges; level sources simply mirror the registered line.
    assign set_evt  = irq_in & ~irq_q & mode_q;
    assign clr      = ((we && addr == ADDR_PEND) ? wdata[NUM_SRC-1:0] : '0)
                    | (ack_take ? (NUM_SRC'(1) << int_id) : '0);
    assign pend_e_d = ((pend_e_q & ~clr) | set_evt) & mode_q;
    assign pend     = (pend_e_q & mode_q) | (irq_q & ~mode_q);
    assign eligible = pend & mask_q;

    int_prio_enc #(
        .N (NUM_SRC)
    ) u_enc (
        .req_i   (eligible),
        .valid_o (enc_valid),
        .id_o    (enc_id)
    );

    // Configuration registers, input synchroniser and edge-pending bits.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: all state is asynchronously cleared while reset is low.
        if (!reset) begin
            mask_q   <= '0;
            mode_q   <= '0;
            irq_q    <= '0;
            pend_e_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
            irq_q    <= irq_in;
            pend_e_q <= pend_e_d;
            if (we && addr == ADDR_MASK) mask_q <= wdata[NUM_SRC-1:0];
            if (we && addr == ADDR_MODE) mode_q <= wdata[NUM_SRC-1:0];
        end
    end

    // FSM state register together with the registered CPU-facing outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            busy_q   <= 1'b0;
            isr_id_q <= '0;
            int_req  <= 1'b0;
            int_id   <= '0;
        end else begin
            state_q  <= state_d;
            busy_q   <= busy_d;
            isr_id_q <= isr_id_d;
            int_req  <= int_req_d;
            int_id   <= int_id_d;
        end
    end

    // Next-state logic; an ack in REQ wins over eligibility dropping in the same cycle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:    if (enc_valid) state_d = ST_REQ;
            ST_REQ: begin
                if (int_ack)         state_d = ST_SERVICE;
                else if (!enc_valid) state_d = ST_IDLE;
            end
            ST_SERVICE: if (eret)      state_d = ST_IDLE;
            default:                   state_d = ST_IDLE;
        endcase
    end

    // Output and in-service bookkeeping; the request tracks the current winner while in REQ.
    always_comb begin
        int_req_d = (state_d == ST_REQ);
        int_id_d  = int_req_d ? enc_id : '0;
        busy_d    = busy_q;
        isr_id_d  = isr_id_q;
        if (ack_take) begin
            busy_d   = 1'b1;
            isr_id_d = int_id;
        end else if (eret_take) begin
            busy_d   = 1'b0;
            isr_id_d = '0;
        end
    end

    // Combinational register read; unused bits read as zero.
    always_comb begin
        rdata = '0;
        unique case (addr)
            ADDR_MASK:   rdata[NUM_SRC-1:0] = mask_q;
            ADDR_MODE:   rdata[NUM_SRC-1:0] = mode_q;
            ADDR_PEND:   rdata[NUM_SRC-1:0] = pend;
            ADDR_STATUS: begin
                rdata[4:2] = isr_id_q;
                rdata[0]   = busy_q;
            end
            default:     rdata = '0;
        endcase
    end

endmodule
